collision_score: RTL and testbench

//  Consumer end of the obstacle interface. Samples the three obstacles' x position and upper-pipe height (o*_x, S_H*) plus player y once per video frame.

---
 rtl/collision_score.sv | 102 ++++++++++
 tb/tb_collision_score.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_score.sv
// collision_score: per-frame player/pipe/boundary collision check, BCD scoring and IDLE/PLAY/OVER game FSM
module collision_score #(
  parameter int P_X   = 160,
  parameter int P_W   = 20,
  parameter int P_H   = 20,
  parameter int T_W   = 29,
  parameter int S_Z   = 120,
  parameter int SCR_H = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [9:0]  p_y,
  input  logic [9:0]  o1_x,
  input  logic [9:0]  o2_x,
  input  logic [9:0]  o3_x,
  input  logic [9:0]  S_H1,
  input  logic [9:0]  S_H2,
  input  logic [9:0]  S_H3,
  output logic [1:0]  state,
  output logic        game_over,
  output logic        hit,
  output logic [15:0] score,
  output logic [15:0] high_score
);
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  state_t state_q, state_d;
  logic [2:0][9:0] ox, sh;
  logic [2:0] pipe, nw, pass;
  logic [10:0] py, py_bot;
  logic [1:0] n;
  logic bound, coll, hit_d;
  logic [15:0] score_d, high_d;
  assign ox = {o3_x, o2_x, o1_x};
  assign sh = {S_H3, S_H2, S_H1};
  assign py = {1'b0, p_y};
  assign py_bot = py + 11'(P_H - 1);
  for (genvar i = 0; i < 3; i++) begin : g_obs
    logic [10:0] x, h;
    assign x = {1'b0, ox[i]};
    assign h = {1'b0, sh[i]};
    assign pipe[i] = x <= 11'(P_X + P_W + T_W - 3) && x >= 11'(P_X) &&
                     (py < h || py_bot >= h + 11'(S_Z - 1));
    assign nw[i] = !pass[i] && x < 11'(P_X);
  end
  assign bound = p_y == 10'd0 || py_bot >= 11'(SCR_H - 1);
  assign coll = bound | |pipe;
  assign n = {1'b0, nw[0]} + {1'b0, nw[1]} + {1'b0, nw[2]};
  // Ripple the 0..3 increment through the digits; a carry out of the top digit saturates.
  function automatic logic [15:0] bcd_inc(input logic [15:0] s, input logic [1:0] a);
    logic [4:0] d;
    logic [1:0] c;
    logic [15:0] r;
    c = a;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      d = {1'b0, s[4*k+:4]} + {3'b0, c};
      c = {1'b0, d > 5'd9};
      r[4*k+:4] = d > 5'd9 ? 4'(d - 5'd10) : d[3:0];
    end
    return c[0] ? 16'h9999 : r;
  endfunction
  always_comb begin
    state_d = state_q;
    score_d = score;
    high_d = high_score;
    hit_d = 1'b0;
    unique case (state_q)
      IDLE: state_d = start ? PLAY : IDLE;
      PLAY: if (frame_tick) begin
        if (coll) begin
          state_d = OVER;
          hit_d = 1'b1;
          high_d = score > high_score ? score : high_score;
        end else score_d = bcd_inc(score, n);
      end
      OVER: if (start) begin
        state_d = IDLE;
        score_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      game_over <= 1'b0;
      hit <= 1'b0;
      score <= '0;
      high_score <= '0;
      pass <= '0;
    end else begin
      state_q <= state_d;
      game_over <= state_d == OVER;
      hit <= hit_d;
      score <= score_d;
      high_score <= high_d;
      if (frame_tick) pass <= {ox[2] < 10'(P_X), ox[1] < 10'(P_X), ox[0] < 10'(P_X)};
    end
  assign state = state_q;
endmodule

// File: tb/tb_collision_score.sv
// tb_collision_score: directed scenarios plus randomized frames checked against a decimal game model
module tb_collision_score;
  logic clk = 1'b0, reset = 1'b0, frame_tick = 1'b0, start = 1'b0;
  logic [9:0] p_y = 10'd150, o1_x = 10'd670, o2_x = 10'd670, o3_x = 10'd670;
  logic [9:0] S_H1 = 10'd100, S_H2 = 10'd100, S_H3 = 10'd100;
  logic [1:0] state;
  logic game_over, hit;
  logic [15:0] score, high_score;
  int checks = 0, errors = 0;
  int m_state, m_score, m_high;
  bit m_hit;
  bit m_pass[3];
  collision_score dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .p_y(p_y),
    .o1_x(o1_x), .o2_x(o2_x), .o3_x(o3_x), .S_H1(S_H1), .S_H2(S_H2), .S_H3(S_H3),
    .state(state), .game_over(game_over), .hit(hit), .score(score), .high_score(high_score)
  );
  always #5 clk = ~clk;
  wire [35:0] obs = {state, game_over, hit, score, high_score};
  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  function automatic logic [35:0] exp_vec();
    return {2'(m_state), m_state == 2, m_hit, bcd(m_score), bcd(m_high)};
  endfunction
  function automatic bit pipe_hit(input int ox, input int sh, input int py);
    bit in_x;
    in_x = ox >= 160 && ox <= 160 + 20 + 29 - 3;
    return in_x && (py < sh || py + 19 >= sh + 119);
  endfunction
  task automatic m_reset();
    m_state = 0; m_score = 0; m_high = 0; m_hit = 0;
    foreach (m_pass[i]) m_pass[i] = 0;
  endtask
  task automatic model_step(input bit ft, input bit st);
    int ox[3], sh[3], gained;
    bit coll;
    ox = '{int'(o1_x), int'(o2_x), int'(o3_x)};
    sh = '{int'(S_H1), int'(S_H2), int'(S_H3)};
    coll = p_y == 0 || int'(p_y) + 19 >= 479;
    gained = 0;
    for (int i = 0; i < 3; i++) begin
      coll |= pipe_hit(ox[i], sh[i], int'(p_y));
      if (!m_pass[i] && ox[i] < 160) gained++;
    end
    m_hit = 0;
    if (m_state == 0) begin
      if (st) m_state = 1;
    end else if (m_state == 1) begin
      if (ft && coll) begin
        m_state = 2; m_hit = 1;
        if (m_score > m_high) m_high = m_score;
      end else if (ft) m_score = m_score + gained > 9999 ? 9999 : m_score + gained;
    end else if (st) begin
      m_state = 0; m_score = 0;
    end
    if (ft) for (int i = 0; i < 3; i++) m_pass[i] = ox[i] < 160;
  endtask
  task automatic cycle(input bit ft, input bit st);
    frame_tick = ft; start = st;
    model_step(ft, st);
    @(posedge clk); #1;
    frame_tick = 0; start = 0;
  endtask
  task automatic test_reset();
    #1 reset = 1;
    m_reset();
    #2;
    checks++;
    if (obs !== 36'h0) begin errors++; $display("FAIL reset_async got=%h want=%h", obs, 36'h0); end
    @(posedge clk); #1 reset = 0;
    cycle(0, 0);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL reset_hold got=%h want=%h", obs, exp_vec()); end
  endtask
  task automatic test_clean_pass();
    cycle(0, 1);
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL start_play got=%0d want=1", state); end
    S_H1 = 100; p_y = 150;
    for (int x = 300; x >= 0; x--) begin
      o1_x = 10'(x);
      cycle(1, 0);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL clean_step x=%0d got=%h want=%h", x, obs, exp_vec()); end
      if (x == 159) begin
        checks++;
        if (score !== 16'h0001) begin errors++; $display("FAIL clean_first got=%h want=0001", score); end
      end
    end
    o1_x = 670;
    cycle(1, 0);
    cycle(1, 0);
    checks++;
    if (score !== 16'h0001 || hit !== 1'b0 || state !== 2'd1) begin
      errors++; $display("FAIL clean_wrap score=%h hit=%b state=%0d want 0001/0/1", score, hit, state);
    end
  endtask
  task automatic test_pipe_hit();
    p_y = 90; S_H1 = 100; o1_x = 170;
    cycle(1, 0);
    checks++;
    if (hit !== 1'b1 || state !== 2'd2 || game_over !== 1'b1 || high_score !== 16'h0001) begin
      errors++; $display("FAIL pipe_hit hit=%b state=%0d go=%b hs=%h want 1/2/1/0001", hit, state, game_over, high_score);
    end
    cycle(0, 0);
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL hit_width got=%b want=0", hit); end
    o1_x = 100;
    repeat (3) cycle(1, 0);
    checks++;
    if (obs !== exp_vec() || score !== 16'h0001) begin errors++; $display("FAIL over_frozen got=%h want=%h", obs, exp_vec()); end
    p_y = 150; o1_x = 670;
    cycle(0, 1);
    checks++;
    if (state !== 2'd0 || score !== 16'h0000 || high_score !== 16'h0001) begin
      errors++; $display("FAIL restart state=%0d score=%h hs=%h want 0/0000/0001", state, score, high_score);
    end
  endtask
  task automatic pass_once(input int k);
    if (k == 1) o1_x = 160; else if (k == 2) o2_x = 160; else o3_x = 160;
    cycle(1, 0);
    if (k == 1) o1_x = 159; else if (k == 2) o2_x = 159; else o3_x = 159;
    cycle(1, 0);
  endtask
  task automatic test_simultaneous();
    cycle(0, 1);
    pass_once(2);
    pass_once(2);
    checks++;
    if (score !== 16'h0002) begin errors++; $display("FAIL sim_setup got=%h want=0002", score); end
    o2_x = 160;
    cycle(1, 0);
    o2_x = 159; p_y = 0;
    cycle(1, 0);
    checks++;
    if (state !== 2'd2 || score !== 16'h0002 || obs !== exp_vec()) begin
      errors++; $display("FAIL sim_coll_wins got=%h want=%h", obs, exp_vec());
    end
    p_y = 150; o2_x = 670;
    cycle(0, 1);
  endtask
  task automatic test_high_score();
    cycle(0, 1);
    for (int i = 0; i < 3; i++) pass_once(1);
    p_y = 0;
    cycle(1, 0);
    checks++;
    if (high_score !== 16'h0003 || state !== 2'd2) begin errors++; $display("FAIL hs_game1 got=%h want=0003", high_score); end
    p_y = 150;
    cycle(0, 1);
    checks++;
    if (state !== 2'd0 || score !== 16'h0000) begin errors++; $display("FAIL hs_idle state=%0d score=%h want 0/0000", state, score); end
    cycle(0, 1);
    pass_once(3);
    p_y = 470;
    cycle(1, 0);
    checks++;
    if (high_score !== 16'h0003 || score !== 16'h0001) begin
      errors++; $display("FAIL hs_game2 hs=%h score=%h want 0003/0001", high_score, score);
    end
    p_y = 150; o1_x = 670; o2_x = 670; o3_x = 670;
    cycle(0, 1);
    cycle(0, 1);
    pass_once(1);
    #2 reset = 1;
    m_reset();
    #1;
    checks++;
    if (obs !== 36'h0) begin errors++; $display("FAIL reset_mid_play got=%h want=%h", obs, 36'h0); end
    @(posedge clk); #1 reset = 0;
    o1_x = 670;
    cycle(1, 0);
  endtask
  task automatic test_bcd_carry();
    bit bad;
    cycle(0, 1);
    for (int i = 1; i <= 100; i++) begin
      pass_once(3);
      bad = 0;
      for (int k = 0; k < 4; k++) if (score[4*k+:4] > 4'd9) bad = 1;
      checks++;
      if (bad || obs !== exp_vec()) begin errors++; $display("FAIL bcd_step i=%0d got=%h want=%h", i, obs, exp_vec()); end
      if (i == 10) begin
        checks++;
        if (score !== 16'h0010) begin errors++; $display("FAIL bcd_10 got=%h want=0010", score); end
      end
    end
    checks++;
    if (score !== 16'h0100) begin errors++; $display("FAIL bcd_100 got=%h want=0100", score); end
    p_y = 0;
    cycle(1, 0);
    p_y = 150;
    cycle(0, 1);
  endtask
  task automatic test_saturation();
    cycle(0, 1);
    for (int i = 0; i < 3335; i++) begin
      o1_x = 160; o2_x = 160; o3_x = 160;
      cycle(1, 0);
      o1_x = 159; o2_x = 159; o3_x = 159;
      cycle(1, 0);
      if (i % 500 == 0 || i > 3325) begin
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL sat_step i=%0d got=%h want=%h", i, obs, exp_vec()); end
      end
    end
    checks++;
    if (score !== 16'h9999) begin errors++; $display("FAIL sat_9999 got=%h want=9999", score); end
    p_y = 479;
    cycle(1, 0);
    checks++;
    if (high_score !== 16'h9999) begin errors++; $display("FAIL sat_high got=%h want=9999", high_score); end
    p_y = 150; o1_x = 670; o2_x = 670; o3_x = 670;
    cycle(0, 1);
  endtask
  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        p_y = 10'($urandom_range(1, 465));
        o1_x = 10'($urandom_range(0, 670)); o2_x = 10'($urandom_range(0, 670)); o3_x = 10'($urandom_range(0, 670));
        S_H1 = 10'($urandom_range(0, 360)); S_H2 = 10'($urandom_range(0, 360)); S_H3 = 10'($urandom_range(0, 360));
        if ($urandom_range(0, 15) == 0) p_y = $urandom_range(0, 1) ? 10'd0 : 10'd460;
      end
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random c=%0d got=%h want=%h", c, obs, exp_vec()); end
    end
  endtask
  initial begin
    m_reset();
    test_reset();
    test_clean_pass();
    test_pipe_hit();
    test_simultaneous();
    test_high_score();
    test_bcd_carry();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
